// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, FSM state type and opcode-class helpers.
package decode_pkg;

  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] BNE  = 6'h05;
  localparam logic [5:0] ANDI = 6'h0C;
  localparam logic [5:0] ORI  = 6'h0D;
  localparam logic [5:0] XORI = 6'h0E;
  localparam logic [5:0] LW   = 6'h23;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic zero_ext_op(input logic [5:0] op);
    return (op == ANDI) || (op == ORI) || (op == XORI);
  endfunction

  // Loads and the I-type ALU group (0x08-0x0F) write rt rather than read it.
  function automatic logic rt_is_dest(input logic [5:0] op);
    return (op == LW) || (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREG x XLEN register file: entry 0 hardwired to zero, two bypassed read ports.
// Optional DECODE_PIPE_DEBUG_EN adds an unbypassed debug read port.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
`ifdef DECODE_PIPE_DEBUG_EN
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
`endif
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] rf [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
    if (gi == 0) begin : g_zero
      assign rf[gi] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (we && waddr == AW'(gi)) begin
          entry_reg <= wdata;
        end
      end
      assign rf[gi] = entry_reg;
    end
  end

  // A write landing this cycle is forwarded so decode never sees stale data.
  assign rdata1 = (we && waddr == raddr1 && raddr1 != '0) ? wdata : rf[raddr1];
  assign rdata2 = (we && waddr == raddr2 && raddr2 != '0) ? wdata : rf[raddr2];

`ifdef DECODE_PIPE_DEBUG_EN
  assign dbg_data = rf[dbg_addr];
`endif

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field extract, bypassed operand read, branch resolve, load-use bubble.
// Optional DECODE_PIPE_DEBUG_EN exposes dbg_addr/dbg_data register-file read.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_memread,
  input  logic [AW-1:0]   ex_rt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [AW-1:0]   out_rs,
  output logic [AW-1:0]   out_rt,
  output logic [AW-1:0]   out_rd,
  output logic            br_taken,
`ifdef DECODE_PIPE_DEBUG_EN
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
`endif
  output logic [XLEN-1:0] br_target
);

  state_t          state_reg, state_next;
  logic [5:0]      op, funct;
  logic [AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] rd1, rd2, sext_imm, imm, target;
  logic            taken, hazard, slot_free, accept;
  logic            unused_shamt;

  assign op           = in_inst[31:26];
  assign funct        = in_inst[5:0];
  assign rs           = in_inst[21 +: AW];
  assign rt           = in_inst[16 +: AW];
  assign rd           = in_inst[11 +: AW];
  assign unused_shamt = ^in_inst[10:6];

  decode_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .raddr1   (rs),
    .raddr2   (rt),
`ifdef DECODE_PIPE_DEBUG_EN
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
`endif
    .rdata1   (rd1),
    .rdata2   (rd2)
  );

  assign sext_imm = XLEN'($signed(in_inst[15:0]));
  assign imm      = zero_ext_op(op) ? XLEN'(in_inst[15:0]) : sext_imm;
  assign target   = in_pc + (sext_imm << 2);
  assign taken    = ((op == BEQ) && (rd1 == rd2)) || ((op == BNE) && (rd1 != rd2));

  // Load-use: rt only matters when this instruction actually reads it.
  assign hazard = in_valid && ex_memread && (ex_rt != '0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && !rt_is_dest(op)));

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && (state_reg == RUN) && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (hazard && slot_free) state_next = BUBBLE;
        BUBBLE:  state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      out_valid <= 1'b0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
      out_op    <= '0;
      out_funct <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        out_valid <= 1'b0;
        br_taken  <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_rd1   <= rd1;
        out_rd2   <= rd2;
        out_imm   <= imm;
        out_op    <= op;
        out_funct <= funct;
        out_rs    <= rs;
        out_rt    <= rt;
        out_rd    <= rd;
        br_taken  <= taken;
        br_target <= target;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        br_taken  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed vector table, hand-written stall/bubble/flush/reset
// sequences, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_decode_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, flush, wb_en, ex_memread, out_valid, out_ready, br_taken;
  logic [XLEN-1:0] in_pc, wb_data, out_rd1, out_rd2, out_imm, br_target;
  logic [31:0]     in_inst;
  logic [AW-1:0]   wb_addr, ex_rt, out_rs, out_rt, out_rd;
  logic [5:0]      out_op, out_funct;
`ifdef DECODE_PIPE_DEBUG_EN
  logic [AW-1:0]   dbg_addr = '0;
  logic [XLEN-1:0] dbg_data;
`endif

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_op(out_op),
    .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .br_taken(br_taken),
`ifdef DECODE_PIPE_DEBUG_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .br_target(br_target)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                     input logic [15:0] low);
    return {op, 5'(rs), 5'(rt), low};
  endfunction

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, inst, pc;
    logic [31:0] rd1, rd2, imm;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        taken;
    logic [31:0] target;
  } bundle_t;

  vec_t        vecs [9];
  logic [31:0] m_rf [32];
  logic        m_valid, m_bubble, n_valid, n_bubble, hz, free, exp_rdy;
  bundle_t     m_b, nb;
  logic [5:0]  ops [9] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};

  // Model register read: zero register, stored value, or same-cycle write forwarding.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bundle_t predict(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t b;
    int simm;
    simm     = int'($signed(inst[15:0]));
    b.op     = inst[31:26];
    b.funct  = inst[5:0];
    b.rs     = inst[25:21];
    b.rt     = inst[20:16];
    b.rd     = inst[15:11];
    b.rd1    = m_read(b.rs);
    b.rd2    = m_read(b.rt);
    b.imm    = (b.op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, inst[15:0]} : 32'(simm);
    b.target = pc + 32'(simm * 4);
    b.taken  = (b.op == 6'h04 && b.rd1 == b.rd2) || (b.op == 6'h05 && b.rd1 != b.rd2);
    return b;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; wb_en = 0; wb_addr = 0;
    wb_data = 0; ex_memread = 0; ex_rt = 0; out_ready = 1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_out_rd1", out_rd1, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_in_ready", in_ready, 1);

    // {wb_en, wb_addr, wb_data, inst, pc, rd1, rd2, imm, taken, target}
    vecs[0] = '{1, 5, 32'hDEADBEEF, mk(6'h08, 5, 1, 16'h8000), 32'h100, 32'hDEADBEEF, 0, 32'hFFFF8000, 0, 32'hFFFE0100};
    vecs[1] = '{1, 0, 32'h12345678, mk(6'h0D, 0, 5, 16'h8000), 32'h40, 0, 32'hDEADBEEF, 32'h00008000, 0, 32'hFFFE0040};
    vecs[2] = '{1, 3, 32'h42, mk(6'h04, 3, 3, 16'hFFFF), 32'h100, 32'h42, 32'h42, 32'hFFFFFFFF, 1, 32'hFC};
    vecs[3] = '{0, 0, 0, mk(6'h05, 5, 0, 16'h0004), 32'h200, 32'hDEADBEEF, 0, 32'h4, 1, 32'h210};
    vecs[4] = '{0, 0, 0, mk(6'h04, 5, 6, 16'h0010), 32'h300, 32'hDEADBEEF, 0, 32'h10, 0, 32'h340};
    vecs[5] = '{1, 6, 32'hDEADBEEF, mk(6'h04, 5, 6, 16'h0001), 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 1, 32'h4};
    vecs[6] = '{0, 0, 0, mk(6'h0E, 0, 3, 16'hFFFF), 32'h1000, 0, 32'h42, 32'h0000FFFF, 0, 32'h0FFC};
    vecs[7] = '{1, 7, 32'h1, mk(6'h23, 0, 7, 16'h0008), 32'h10, 0, 32'h1, 32'h8, 0, 32'h30};
    vecs[8] = '{0, 0, 0, mk(6'h00, 0, 0, 16'h2020), 32'h0, 0, 0, 32'h2020, 0, 32'h8080};

    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_inst = vecs[i].inst; in_pc = vecs[i].pc; out_ready = 1; ex_memread = 0;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      #1;
      chk("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 0; wb_en = 0;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_rd1", out_rd1, vecs[i].rd1);
      chk("vec_rd2", out_rd2, vecs[i].rd2);
      chk("vec_imm", out_imm, vecs[i].imm);
      chk("vec_taken", br_taken, vecs[i].taken);
      chk("vec_target", br_target, vecs[i].target);
      chk("vec_fields", {out_op, out_funct, out_rs, out_rt, out_rd},
          {vecs[i].inst[31:26], vecs[i].inst[5:0], vecs[i].inst[25:21], vecs[i].inst[20:16],
           vecs[i].inst[15:11]});
      $display("vec %0d inst=%08h pc=%08h rd1=%08h rd2=%08h imm=%08h taken=%0d target=%08h",
               i, vecs[i].inst, vecs[i].pc, out_rd1, out_rd2, out_imm, br_taken, br_target);
    end

    // Load-use: rt-as-destination and ex_rt==0 do not stall; add reading the load result does.
    wb_en = 1; wb_addr = 8; wb_data = 32'h8888; tick(); wb_en = 0;
    in_valid = 1; ex_memread = 1; ex_rt = 8; in_inst = mk(6'h0D, 1, 8, 16'h0001);
    #1; chk("ori_rt_dest_no_hazard", in_ready, 1); tick();
    ex_rt = 0; in_inst = mk(6'h00, 0, 0, 16'h0020);
    #1; chk("ex_rt0_no_hazard", in_ready, 1); tick();
    ex_rt = 8; in_inst = mk(6'h00, 8, 2, 16'h2020);
    #1; chk("loaduse_in_ready", in_ready, 0); tick();
    ex_memread = 0;
    chk("bubble_out_valid", out_valid, 0);
    #1; chk("bubble_in_ready", in_ready, 0); tick();
    chk("post_bubble_out_valid", out_valid, 0);
    #1; chk("post_bubble_in_ready", in_ready, 1); tick();
    in_valid = 0;
    chk("loaduse_issue_valid", out_valid, 1);
    chk("loaduse_issue_rd1", out_rd1, 32'h8888);
    chk("loaduse_issue_rs", out_rs, 8);
    $display("txn loaduse inst=%08h rd1=%08h", in_inst, out_rd1);
    tick();

    // Back-pressure hold for 3 cycles (with a register write underneath), then flush.
    in_valid = 1; in_inst = mk(6'h05, 5, 0, 16'h0004); in_pc = 32'h200; out_ready = 1;
    tick();
    in_inst = mk(6'h08, 1, 2, 16'h1234); out_ready = 0;
    wb_en = 1; wb_addr = 5; wb_data = 32'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_rd1", out_rd1, 32'hDEADBEEF);
      chk("hold_target", br_target, 32'h210);
      chk("hold_taken", br_taken, 1);
      tick();
      wb_en = 0;
    end
    flush = 1;
    #1; chk("flush_blocks_accept", in_ready, 0); tick();
    flush = 0;
    chk("flush_out_valid", out_valid, 0);
    in_inst = mk(6'h00, 5, 0, 16'h0000); out_ready = 1;
    #1; chk("after_flush_in_ready", in_ready, 1); tick();
    chk("write_during_stall_rd1", out_rd1, 32'h55);
    $display("txn hold+flush rd1_after=%08h", out_rd1);

    // Reset while stalled abandons the bundle and clears the register file.
    out_ready = 0; rst = 1; tick(); rst = 0;
    chk("rst_stall_out_valid", out_valid, 0);
    chk("rst_stall_rd1", out_rd1, 0);
    chk("rst_stall_target", br_target, 0);
    out_ready = 1;
    #1; chk("rst_stall_in_ready", in_ready, 1); tick();
    in_valid = 0;
    chk("rst_cleared_reg5", out_rd1, 0);
    $display("txn reset-mid-stall rd1=%08h", out_rd1);

    // Randomized traffic against the model.
    rst = 1; tick(); rst = 0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    m_valid = 0; m_bubble = 0; m_b = '0;
    for (int c = 0; c < 500; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_inst    = mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7),
                      16'($urandom));
      in_pc      = $urandom;
      wb_en      = ($urandom_range(0, 1) == 1);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_rt      = 5'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      #1;
      hz = in_valid && ex_memread && ex_rt != 0 &&
           (ex_rt == in_inst[25:21] ||
            (ex_rt == in_inst[20:16] &&
             !(in_inst[31:26] inside {6'h23, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F})));
      free    = !m_valid || out_ready;
      exp_rdy = free && !hz && !m_bubble && !flush;
      chk("rnd_in_ready", in_ready, exp_rdy);
      nb = predict(in_inst, in_pc);
      n_valid = m_valid;
      n_bubble = 0;
      if (flush) begin
        n_valid = 0;
      end else begin
        if (in_valid && exp_rdy) n_valid = 1;
        else if (out_ready) n_valid = 0;
        n_bubble = !m_bubble && hz && free;
      end
      tick();
      if (!flush && in_valid && exp_rdy) begin
        m_b = nb;
        $display("rnd txn cyc=%0d inst=%08h pc=%08h rd1=%08h rd2=%08h", c, in_inst, in_pc, nb.rd1, nb.rd2);
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
      m_valid = n_valid;
      m_bubble = n_bubble;
      chk("rnd_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_rd1", out_rd1, m_b.rd1);
        chk("rnd_rd2", out_rd2, m_b.rd2);
        chk("rnd_imm", out_imm, m_b.imm);
        chk("rnd_branch", {br_taken, br_target}, {m_b.taken, m_b.target});
        chk("rnd_fields", {out_op, out_funct, out_rs, out_rt, out_rd},
            {m_b.op, m_b.funct, m_b.rs, m_b.rt, m_b.rd});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, data/PC width (≥16).
- NREG, 32, register count (power of two); AW = $clog2(NREG).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetched instruction valid.
- in_ready  out  1  decode accepts instruction this cycle.
- in_pc  in  XLEN  PC+4 of fetched instruction.
- in_inst  in  32  instruction word.
- flush  in  1  discard accepted/pending instruction.
- wb_en  in  1  write-back enable.
- wb_addr  in  AW  write-back register.
- wb_data  in  XLEN  write-back data.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  AW  load destination in EX.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EX accepts bundle.
- out_rd1, out_rd2  out  XLEN  operand values.
- out_imm  out  XLEN  extended immediate.
- out_op / out_funct  out  6 / 6  inst[31:26] / inst[5:0].
- out_rs, out_rt, out_rd  out  AW  register fields (low AW bits of 5-bit fields).
- br_taken  out  1  branch resolved taken, qualified by out_valid.
- br_target  out  XLEN  branch target.

Function
REQ-003 Register file SHALL hold NREG×XLEN entries; entry 0 reads zero, writes to it ignored; write on clk edge when wb_en.
REQ-004 Reads SHALL bypass: wb_en && wb_addr==rs && wb_addr!=0 -> rd1 = wb_data (same for rt/rd2).
REQ-005 Immediate SHALL sign-extend inst[15:0] to XLEN; ops 0x0C/0x0D/0x0E SHALL zero-extend.
REQ-006 br_target SHALL equal in_pc + (sign-ext imm << 2), modulo 2^XLEN.
REQ-007 br_taken SHALL be 1 for op 0x04 with bypassed rd1==rd2, or op 0x05 with rd1!=rd2; else 0.
REQ-008 Output bundle SHALL be registered; latency one cycle from acceptance (in_valid && in_ready).
REQ-009 in_ready SHALL equal (!out_valid || out_ready) && !hazard && state==RUN.
REQ-010 hazard SHALL be in_valid && ex_memread && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && op not in {0x23, I-type ALU ops})).
REQ-011 FSM RUN->BUBBLE on hazard while output slot free; BUBBLE inserts out_valid=0 for exactly one cycle, then RUN; instruction held upstream and accepted in RUN.
REQ-012 While out_valid && !out_ready all outputs SHALL hold stable.
REQ-013 flush SHALL clear out_valid next cycle, block acceptance that cycle, and return FSM to RUN; flush wins over hazard and acceptance.
REQ-014 Register writes SHALL proceed regardless of stall, bubble or flush.

Reset
REQ-015 On rst all registers, out_valid, br_taken, every output register SHALL be 0 and FSM RUN; rst mid-bubble or mid-stall abandons the instruction.

Configuration
REQ-016 With DECODE_PIPE_DEBUG_EN defined, ports dbg_addr (in, AW) and dbg_data (out, XLEN) SHALL give combinational register-file read (no bypass); without it the ports SHALL not exist and no extra logic is built.

Structure
REQ-017 Shared package decode_pkg SHALL hold opcode constants (BEQ, BNE, LW, ANDI, ORI, XORI) and FSM state typedef.
REQ-018 Register file SHALL be sub-module decode_regfile (params XLEN, NREG).

Verification
REQ-019 wb_en=1, wb_addr=5, wb_data=0xDEAD_BEEF with in_inst rs=5 same cycle -> out_rd1=0xDEAD_BEEF next cycle.
REQ-020 ex_memread=1, ex_rt=8, inst add rs=8 -> in_ready=0, one out_valid=0 cycle, then bundle issued.
REQ-021 beq rs=rt=3, in_pc=0x100, imm=0xFFFF -> br_taken=1, br_target=0xFC.
REQ-022 out_ready=0 for 3 cycles with valid bundle -> outputs stable, in_ready=0; flush during hold -> out_valid=0 next cycle.
REQ-023 ori imm=0x8000 -> out_imm=0x0000_8000; addi imm=0x8000 -> 0xFFFF_8000; write to reg 0 -> reads 0.
